// File: rtl/sram_ctrl_pkg.sv
// Shared constants and state encoding for the bank SRAM access controller.
// Imported by the controller top and its clear walker.
package sram_ctrl_pkg;

   localparam int SETS   = 128;
   localparam int ADDR_W = $clog2(SETS);
   localparam int DATA_W = 16;
   localparam int MASK_W = 8;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

endpackage

// File: rtl/sram_clear_walker.sv
// Set pointer for the post-reset clear walk.
// Stops on the last set; o_last marks the final clear write.
module sram_clear_walker
   import sram_ctrl_pkg::*;
(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_en,
   output logic [ADDR_W-1:0] o_ptr,
   output logic              o_last
);

   logic [ADDR_W-1:0] r_ptr;
   logic              w_last;

   assign w_last = (r_ptr == ADDR_W'(SETS - 1));

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_ptr <= '0;
      end else if (i_en && !w_last) begin
         r_ptr <= r_ptr + 1'b1;
      end
   end

   assign o_ptr  = r_ptr;
   assign o_last = w_last;

endmodule

// File: rtl/sram_access_ctrl.sv
// Requester-side controller for one 1R1W bank SRAM: clear walk,
// read/write handshakes, collision arbitration and a held read response.
module sram_access_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter bit CLEAR_ON_RESET = 1'b1
)
(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_req_r_valid,
   output logic              o_req_r_ready,
   input  logic [ADDR_W-1:0] i_req_r_addr,
   output logic              o_resp_valid,
   input  logic              i_resp_ready,
   output logic [DATA_W-1:0] o_resp_data,
   input  logic              i_req_w_valid,
   output logic              o_req_w_ready,
   input  logic [ADDR_W-1:0] i_req_w_addr,
   input  logic [DATA_W-1:0] i_req_w_data,
   input  logic [MASK_W-1:0] i_req_w_mask,
   output logic              o_init_done,
   output logic [ADDR_W-1:0] o_sram_r_addr,
   input  logic [DATA_W-1:0] i_sram_r_data,
   output logic              o_sram_w_en,
   output logic [ADDR_W-1:0] o_sram_w_addr,
   output logic [DATA_W-1:0] o_sram_w_data,
   output logic [MASK_W-1:0] o_sram_w_mask
);

   state_t            r_state;
   state_t            w_state_nxt;

   logic              w_clr_en;
   logic              w_clr_last;
   logic [ADDR_W-1:0] w_clr_ptr;

   logic              w_run;
   logic              w_w_fire;
   logic              w_collide;
   logic              w_stall;
   logic              w_r_fire;

   logic              r_resp_valid;
   logic              r_fresh;
   logic [DATA_W-1:0] r_hold;
   logic [ADDR_W-1:0] r_raddr;

   sram_clear_walker u_walker (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_en    (w_clr_en),
      .o_ptr   (w_clr_ptr),
      .o_last  (w_clr_last)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   assign w_run    = (r_state == ST_RUN);
   assign w_w_fire = w_run & i_req_w_valid;

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_en      = 1'b0;
      o_sram_w_en   = 1'b0;
      o_sram_w_addr = i_req_w_addr;
      o_sram_w_data = i_req_w_data;
      o_sram_w_mask = i_req_w_mask;
      unique case (r_state)
         ST_CLEAR: begin
            w_clr_en      = 1'b1;
            o_sram_w_en   = 1'b1;
            o_sram_w_addr = w_clr_ptr;
            o_sram_w_data = '0;
            o_sram_w_mask = '1;
            if (w_clr_last) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            o_sram_w_en = w_w_fire;
         end
      endcase
   end

   // A write to the same set wins; the read is retried next cycle.
   assign w_collide = w_w_fire & i_req_r_valid
                    & (i_req_r_addr == i_req_w_addr);
   assign w_stall   = r_resp_valid & ~i_resp_ready;

   assign o_req_r_ready = w_run & ~w_stall & ~w_collide;
   assign o_req_w_ready = w_run;
   assign w_r_fire      = i_req_r_valid & o_req_r_ready;

   // Read port keeps the last accepted set while no new read fires.
   assign o_sram_r_addr = w_r_fire ? i_req_r_addr : r_raddr;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_resp_valid <= 1'b0;
         r_fresh      <= 1'b0;
         r_hold       <= '0;
         r_raddr      <= '0;
      end else begin
         r_fresh <= w_r_fire;
         if (w_r_fire) begin
            r_raddr <= i_req_r_addr;
         end
         if (r_fresh) begin
            r_hold <= i_sram_r_data;
         end
         if (w_r_fire) begin
            r_resp_valid <= 1'b1;
         end else if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
         end
      end
   end

   // Fresh SRAM data on the first response cycle, held copy afterwards.
   assign o_resp_data  = r_fresh ? i_sram_r_data : r_hold;
   assign o_resp_valid = r_resp_valid;
   assign o_init_done  = w_run;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl with a behavioural SRAM and a
// reference memory feeding a response scoreboard.
module tb_sram_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        r_valid = 1'b0;
   logic        r_ready;
   logic [6:0]  r_addr = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [15:0] resp_data;
   logic        w_valid = 1'b0;
   logic        w_ready;
   logic [6:0]  w_addr = '0;
   logic [15:0] w_data = '0;
   logic [7:0]  w_mask = '0;
   logic        init_done;
   logic [6:0]  s_raddr;
   logic [15:0] s_rdata;
   logic        s_wen;
   logic [6:0]  s_waddr;
   logic [15:0] s_wdata;
   logic [7:0]  s_wmask;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] mem [128];
   logic [15:0] ref_mem [128];
   logic [15:0] sb [$];
   logic [15:0] last_resp = '0;
   logic [15:0] nv;

   always #5 clk = ~clk;

   sram_access_ctrl dut (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_req_r_valid (r_valid),
      .o_req_r_ready (r_ready),
      .i_req_r_addr  (r_addr),
      .o_resp_valid  (resp_valid),
      .i_resp_ready  (resp_ready),
      .o_resp_data   (resp_data),
      .i_req_w_valid (w_valid),
      .o_req_w_ready (w_ready),
      .i_req_w_addr  (w_addr),
      .i_req_w_data  (w_data),
      .i_req_w_mask  (w_mask),
      .o_init_done   (init_done),
      .o_sram_r_addr (s_raddr),
      .i_sram_r_data (s_rdata),
      .o_sram_w_en   (s_wen),
      .o_sram_w_addr (s_waddr),
      .o_sram_w_data (s_wdata),
      .o_sram_w_mask (s_wmask)
   );

   function automatic logic [15:0] bitmask(input logic [7:0] m);
      logic [15:0] b;
      for (int i = 0; i < 16; i++) b[i] = m[i / 2];
      return b;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Behavioural 1R1W SRAM, registered read, random power-up contents
   initial for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);

   always @(posedge clk) begin
      if (s_wen) begin
         nv = (mem[s_waddr] & ~bitmask(s_wmask)) | (s_wdata & bitmask(s_wmask));
         mem[s_waddr] <= nv;
      end
      s_rdata <= mem[s_raddr];
   end

   // Scoreboard monitor, mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         for (int i = 0; i < 128; i++) ref_mem[i] = '0;
      end else begin
         if (resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
               chk("resp_unexpected", 1, 0);
            end else begin
               chk("resp_data", resp_data, sb.pop_front());
               last_resp = resp_data;
            end
         end
         if (r_valid && r_ready) sb.push_back(ref_mem[r_addr]);
         if (w_valid && w_ready)
            ref_mem[w_addr] = (ref_mem[w_addr] & ~bitmask(w_mask))
                            | (w_data & bitmask(w_mask));
      end
   end

   task automatic wr(input logic [6:0] a, input logic [15:0] d,
                     input logic [7:0] m);
      w_valid = 1'b1; w_addr = a; w_data = d; w_mask = m;
      @(posedge clk); #1;
      w_valid = 1'b0;
   endtask

   task automatic rd(input logic [6:0] a);
      bit ok = 0;
      r_valid = 1'b1; r_addr = a;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (r_ready) begin ok = 1; break; end
      end
      chk("rd_accept", ok, 1);
      @(posedge clk); #1;
      r_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 20; k++) begin
         if (sb.size() == 0) break;
         @(posedge clk); #1;
      end
      chk("drain", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=hang exp=finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [6:0] ka;
      bit rf;
      int cyc;

      // Test 1: clear walk, requests ignored
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", {init_done, r_ready, w_ready, resp_valid}, 4'b0000);
      rst = 1'b0;
      r_valid = 1'b1; w_valid = 1'b1; w_data = 16'hFFFF; w_mask = 8'h0F;
      for (int k = 0; k < 128; k++) begin
         ka = 7'(k);
         @(negedge clk);
         chk("t1_clear",
             {s_wen, s_waddr, s_wdata, s_wmask, init_done, r_ready, w_ready},
             {1'b1, ka, 16'h0000, 8'hFF, 3'b000});
      end
      @(posedge clk); #1;
      r_valid = 1'b0; w_valid = 1'b0;
      @(negedge clk);
      chk("t1_done", {init_done, w_ready, s_wen}, 3'b110);
      @(posedge clk); #1;

      // Test 2: write then read back
      wr(7'd5, 16'h1234, 8'hFF);
      rd(7'd5);
      drain();
      chk("t2_resp", last_resp, 16'h1234);

      // Test 3: partial mask over cleared set
      wr(7'd9, 16'hFFFF, 8'h0F);
      rd(7'd9);
      drain();
      chk("t3_resp", last_resp, 16'h00FF);

      // Test 4: same-cycle collision
      w_valid = 1'b1; w_addr = 7'd3; w_data = 16'hABCD; w_mask = 8'hFF;
      r_valid = 1'b1; r_addr = 7'd3;
      @(negedge clk);
      chk("t4_collide_rdy", {r_ready, s_wen}, 2'b01);
      @(posedge clk); #1;
      w_valid = 1'b0;
      @(negedge clk);
      chk("t4_retry_rdy", r_ready, 1);
      @(posedge clk); #1;
      r_valid = 1'b0;
      drain();
      chk("t4_resp", last_resp, 16'hABCD);

      // Test 5: response backpressure, write under the held set
      wr(7'd20, 16'h5A5A, 8'hFF);
      wr(7'd21, 16'h0F0F, 8'hFF);
      resp_ready = 1'b0;
      r_valid = 1'b1; r_addr = 7'd20;
      @(negedge clk);
      chk("t5_fire", r_ready, 1);
      @(posedge clk); #1;
      r_addr = 7'd21;
      w_valid = 1'b1; w_addr = 7'd20; w_data = 16'h1111; w_mask = 8'hFF;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk("t5_stall", {resp_valid, resp_data, r_ready, s_raddr},
             {1'b1, 16'h5A5A, 1'b0, 7'd20});
         @(posedge clk); #1;
         w_valid = 1'b0;
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("t5_consume_fire", r_ready, 1);
      @(posedge clk); #1;
      r_valid = 1'b0;
      drain();
      chk("t5_resp2", last_resp, 16'h0F0F);

      // Random mixed traffic over a small set range
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         rf = r_valid && r_ready;
         @(posedge clk); #1;
         if (!r_valid || rf) begin
            r_valid = 1'($urandom_range(0, 1));
            r_addr = 7'($urandom_range(0, 7));
         end
         w_valid = 1'($urandom_range(0, 1));
         w_addr = 7'($urandom_range(0, 7));
         w_data = 16'($urandom);
         w_mask = 8'($urandom);
         resp_ready = ($urandom_range(0, 3) != 0);
      end
      w_valid = 1'b0;
      resp_ready = 1'b1;
      if (r_valid) rd(r_addr);
      drain();

      // Test 6: reset drops pending response, then reset mid-clear
      resp_ready = 1'b0;
      rd(7'd3);
      chk("t6_pending", resp_valid, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("t6_flush", {resp_valid, init_done, r_ready}, 3'b000);
      rst = 1'b0;
      resp_ready = 1'b1;
      repeat (40) @(negedge clk);
      @(posedge clk); #1;
      chk("t6_ptr40", s_waddr, 7'd40);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      cyc = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (k == 0) chk("t6_restart", {s_wen, s_waddr}, {1'b1, 7'd0});
         if (init_done) break;
         cyc++;
      end
      chk("t6_clear_len", cyc, 128);
      @(posedge clk); #1;
      rd(7'd5);
      drain();
      chk("t6_cleared", last_resp, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
